uart_out_arbiter: RTL and testbench
===================================

// Module: uart_out_arbiter
// PURPOSE
//  Shares the single simulation UART character sink among NUM_REQ requesters (harts/devices).
//  Grants are line-atomic: one requester owns the sink until it sends newline, hits MAX_LINE
//  chars or stalls IDLE_TIMEOUT cycles, so console lines never interleave. Round-robin fairness.
//  Sits between the per-core uart_out streams and the top-level console writer.
// PARAMETERS
//  NUM_REQ       4    number of requesters (>=2)
//  MAX_LINE      128  chars accepted in one grant before forced release (>=1)
//  IDLE_TIMEOUT  64   consecutive owner-not-valid cycles before forced release (>=1)
// PORTS
//  clock          in   1               clock, all state on rising edge
//  reset          in   1               reset, synchronous, active-low
//  req_valid      in   NUM_REQ         per-requester char valid
//  req_ch         in   NUM_REQ*8       per-requester char, requester i at [8i+7:8i]
//  req_ready      out  NUM_REQ         per-requester accept; at most one bit set
//  out_valid      out  1               registered char to sink valid
//  out_ch         out  8               registered char
//  out_src        out  $clog2(NUM_REQ) requester index of out_ch
//  out_ready      in   1               sink accepts (tie 1 for $fwrite sink)
//  busy           out  1               a grant is held (state LOCKED)
//  release_pulse  out  1               1-cycle pulse when a grant ends
//  release_cause  out  2               valid with pulse: 0 newline, 1 max_line, 2 timeout
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE, owner 0, rr_ptr 0, char_cnt 0, idle_cnt 0, out_valid 0,
//   out_ch 0, out_src 0, release_pulse 0, release_cause 0. Buffered char is dropped, not sent.
//  FSM IDLE: if any req_valid, pick first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   owner<=pick, ->LOCKED next cycle. No req_ready in IDLE (1 cycle arbitration bubble).
//  FSM LOCKED: req_ready[owner] = !out_valid || out_ready; all other bits 0.
//   Accept = req_valid[owner] & req_ready[owner]: out_ch<=char, out_src<=owner, out_valid<=1,
//   char_cnt++, idle_cnt<=0. Char to sink latency 1 cycle after accept.
//  Output reg: out_valid clears on out_ready when no new accept same cycle; holds value while
//   out_valid & !out_ready. Accept and drain in same cycle allowed (full throughput, 1 char/cyc).
//  Release (->IDLE, rr_ptr<=owner+1 mod NUM_REQ, char_cnt<=0, idle_cnt<=0, pulse next cycle):
//   newline: accepted char==8'h0A, cause 0 (the newline itself is forwarded).
//   max_line: accept making char_cnt==MAX_LINE, cause 1. Newline on same char -> cause 0 wins.
//   timeout: owner req_valid==0 for IDLE_TIMEOUT consecutive LOCKED cycles, cause 2.
//   Stall by out_ready==0 while owner valid does not count as idle.
//  Release is registered; the char buffered at release still drains in IDLE.
//  Counters: char_cnt width $clog2(MAX_LINE+1), idle_cnt $clog2(IDLE_TIMEOUT+1), saturating.
//  Requester dropping req_valid mid-line: no error, only counts toward timeout.
//  Single active requester: re-granted after 1 bubble cycle per line.
// STRUCTURE
//  Package sim_uart_pkg: typedef enum {ARB_IDLE, ARB_LOCKED} arb_state_t; localparam
//   NEWLINE=8'h0A; typedef enum logic[1:0] {REL_NL, REL_MAX, REL_TMO} rel_cause_t.
//  Sub-module rr_pick #(N): comb, inputs req[N], ptr; outputs any, idx (first set from ptr).
//  Top: FSM + counters + output register.
// TESTING
//  Reset: drive reset=0 3 cycles with all req_valid=1 -> out_valid=0, req_ready=0, busy=0.
//  Two lines: req0 "ab\n", req1 "xy\n" both valid at once -> sink sees a,b,\n (src0) then
//   x,y,\n (src1), no interleave; release_pulse x2 cause 0; rr_ptr then 2.
//  MAX_LINE=4, req2 sends 6 chars no newline -> 4 chars src2, pulse cause 1, re-arbitrate.
//  IDLE_TIMEOUT=8: req1 sends 'q' then drops valid, req3 waiting -> after 8 idle cycles pulse
//   cause 2, next char from src3.
//  Backpressure: out_ready low 5 cycles mid-line -> out_ch held stable, req_ready[owner]=0, no
//   timeout, no loss; releasing out_ready resumes 1 char/cycle.
//  Reset mid-line with out_valid=1 -> next cycle out_valid=0, busy=0; char is dropped.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the simulation UART console arbiter.
package sim_uart_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic [1:0] {
    REL_NL  = 2'd0,
    REL_MAX = 2'd1,
    REL_TMO = 2'd2
  } rel_cause_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end
  end

endmodule

// File: rtl/uart_out_arbiter.sv
// Line-atomic round-robin arbiter feeding one console character sink.
//
// state      | meaning
// ARB_IDLE   | no grant held; arbitrate among valid requesters (one bubble cycle)
// ARB_LOCKED | owner holds the sink until newline, max line length or idle timeout
module uart_out_arbiter
  import sim_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_LINE     = 128,
  parameter int IDLE_TIMEOUT = 64,
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_ch,
  output logic [SW-1:0]        out_src,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 release_pulse,
  output logic [1:0]           release_cause
);

  localparam int CW = $clog2(MAX_LINE + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t state, state_nxt;
  logic [SW-1:0] owner, owner_nxt;
  logic [SW-1:0] rr_ptr, rr_nxt;
  logic [CW-1:0] char_cnt, char_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_valid;
  logic [7:0]    owner_ch;
  logic          owner_ready;
  logic          accept;
  logic          rel;
  rel_cause_t    cause_nxt;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy = (state == ARB_LOCKED);

  // Next-state, handshake and line-release decisions.
  always_comb begin
    owner_valid = req_valid[owner];
    owner_ch    = req_ch[{owner, 3'b000} +: 8];
    owner_ready = (state == ARB_LOCKED) && (!out_valid || out_ready);
    req_ready   = '0;
    if (owner_ready) req_ready[owner] = 1'b1;
    accept    = owner_valid && owner_ready;
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    char_nxt  = char_cnt;
    idle_nxt  = idle_cnt;
    rel       = 1'b0;
    cause_nxt = REL_NL;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_nxt = pick_idx;
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          idle_nxt = '0;
          if (char_cnt != CW'(MAX_LINE)) char_nxt = char_cnt + CW'(1);
          // Newline takes precedence when it is also the line-filling char.
          if (owner_ch == NEWLINE) begin
            rel       = 1'b1;
            cause_nxt = REL_NL;
          end else if (char_cnt == CW'(MAX_LINE - 1)) begin
            rel       = 1'b1;
            cause_nxt = REL_MAX;
          end
        end else if (!owner_valid) begin
          if (idle_cnt != IW'(IDLE_TIMEOUT)) idle_nxt = idle_cnt + IW'(1);
          if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
            rel       = 1'b1;
            cause_nxt = REL_TMO;
          end
        end else begin
          // Owner has data but the sink is stalled: not idle.
          idle_nxt = '0;
        end
        if (rel) begin
          state_nxt = ARB_IDLE;
          rr_nxt    = (owner == SW'(NUM_REQ - 1)) ? '0 : owner + SW'(1);
          char_nxt  = '0;
          idle_nxt  = '0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, counters and the one-deep output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      owner         <= '0;
      rr_ptr        <= '0;
      char_cnt      <= '0;
      idle_cnt      <= '0;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_src       <= '0;
      release_pulse <= 1'b0;
      release_cause <= 2'd0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      rr_ptr        <= rr_nxt;
      char_cnt      <= char_nxt;
      idle_cnt      <= idle_nxt;
      release_pulse <= rel;
      if (rel) release_cause <= cause_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_ch    <= owner_ch;
        out_src   <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Bench for uart_out_arbiter: cycle model of the arbitration rules plus
// hand-written expected console streams and release causes per scenario.
module tb_uart_out_arbiter;

  localparam int N  = 4;
  localparam int ML = 4;
  localparam int TO = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_ch;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_ch;
  logic [1:0]     out_src;
  logic           out_ready;
  logic           busy;
  logic           release_pulse;
  logic [1:0]     release_cause;

  uart_out_arbiter #(.NUM_REQ(N), .MAX_LINE(ML), .IDLE_TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ch        (req_ch),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_ch        (out_ch),
    .out_src       (out_src),
    .out_ready     (out_ready),
    .busy          (busy),
    .release_pulse (release_pulse),
    .release_cause (release_cause)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // behavioural model
  bit         model_known = 0;
  bit         m_locked;
  int         m_owner, m_rr, m_cnt, m_idle;
  bit         m_ov;
  logic [7:0] m_och;
  int         m_osrc;
  bit         m_pulse;
  int         m_cause;
  bit         m_rel;

  // stimulus and observation queues
  logic [7:0] q[N][$];
  bit         use_q = 0;
  int         sink_q[$];
  int         sink_cyc[$];
  int         pulse_q[$];
  int         pulse_cyc[$];
  int         want_sink[$];
  int         want_pulse[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] m = '0;
    if (m_locked && (!m_ov || out_ready)) m[m_owner] = 1'b1;
    return m;
  endfunction

  task automatic end_line(input int c);
    m_locked = 0;
    m_rr     = (m_owner + 1) % N;
    m_cnt    = 0;
    m_idle   = 0;
    m_rel    = 1;
    m_cause  = c;
  endtask

  task automatic model_step();
    bit         acc;
    bit         found;
    logic [7:0] ch;
    if (!reset) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_idle = 0;
      m_ov = 0; m_och = 8'h00; m_osrc = 0; m_pulse = 0; m_cause = 0;
      model_known = 1;
      return;
    end
    acc   = m_locked && req_valid[m_owner] && (!m_ov || out_ready);
    ch    = req_ch[m_owner*8 +: 8];
    m_rel = 0;
    found = 0;
    if (acc) begin
      m_ov = 1; m_och = ch; m_osrc = m_owner;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_rr + k) % N]) begin
          found    = 1;
          m_owner  = (m_rr + k) % N;
          m_locked = 1;
        end
      end
    end else if (acc) begin
      m_cnt++;
      m_idle = 0;
      if (ch == 8'h0A) end_line(0);
      else if (m_cnt == ML) end_line(1);
    end else if (!req_valid[m_owner]) begin
      m_idle++;
      if (m_idle == TO) end_line(2);
    end else begin
      m_idle = 0;
    end
    m_pulse = m_rel;
  endtask

  task automatic drive_from_queues();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = (q[i].size() > 0);
      req_ch[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  // One clock: drive, compare DUT against model, record sink, advance model.
  task automatic cycle();
    logic [N-1:0] mr;
    if (use_q) drive_from_queues();
    #1;
    mr = model_ready();
    if (model_known) begin
      chk("req_ready", 32'(req_ready), 32'(mr));
      chk("busy", 32'(busy), 32'(m_locked));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("release_pulse", 32'(release_pulse), 32'(m_pulse));
      if (m_ov) begin
        chk("out_ch", 32'(out_ch), 32'(m_och));
        chk("out_src", 32'(out_src), 32'(m_osrc));
      end
      if (m_pulse) chk("release_cause", 32'(release_cause), 32'(m_cause));
      if (out_valid === 1'b1 && out_ready) begin
        sink_q.push_back(int'(out_src) * 256 + int'(out_ch));
        sink_cyc.push_back(cyc);
      end
      if (release_pulse === 1'b1) begin
        pulse_q.push_back(int'(release_cause));
        pulse_cyc.push_back(cyc);
      end
    end
    if (use_q) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && mr[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    model_step();
    cyc++;
    @(negedge clock);
  endtask

  task automatic push_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) q[i].push_back(s[k]);
  endtask

  task automatic add_exp(input string s, input int src);
    for (int k = 0; k < s.len(); k++) want_sink.push_back(src * 256 + int'(s[k]));
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += q[i].size();
    return n;
  endfunction

  task automatic drain(input string name, input int extra);
    int n = 0;
    while (pending() > 0 && n < 300) begin
      cycle();
      n++;
    end
    chk({name, " drained"}, 32'(pending()), 32'd0);
    repeat (extra) cycle();
  endtask

  task automatic check_results(input string name);
    chk({name, " sink length"}, 32'(sink_q.size()), 32'(want_sink.size()));
    for (int i = 0; i < sink_q.size() && i < want_sink.size(); i++)
      chk({name, " sink char"}, 32'(sink_q[i]), 32'(want_sink[i]));
    chk({name, " pulse count"}, 32'(pulse_q.size()), 32'(want_pulse.size()));
    for (int i = 0; i < pulse_q.size() && i < want_pulse.size(); i++)
      chk({name, " cause"}, 32'(pulse_q[i]), 32'(want_pulse[i]));
    sink_q.delete(); sink_cyc.delete(); pulse_q.delete(); pulse_cyc.delete();
    want_sink.delete(); want_pulse.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int stall;
    int n;
    bit sp, sq;

    // reset held 3 cycles with every requester asserting valid
    reset     = 1'b0;
    req_valid = '1;
    req_ch    = '0;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    use_q = 1;
    repeat (2) cycle();

    // two complete lines requested simultaneously
    push_str(0, "ab\n");
    push_str(1, "xy\n");
    drain("two_lines", 6);
    add_exp("ab\n", 0);
    add_exp("xy\n", 1);
    want_pulse = '{0, 0};
    check_results("two_lines");

    // pointer now at 2; req2 hits the line limit, req0 wins next, req2 times out
    push_str(2, "abcdef");
    push_str(0, "Z\n");
    drain("max_line", 14);
    add_exp("abcd", 2);
    add_exp("Z\n", 0);
    add_exp("ef", 2);
    want_pulse = '{1, 0, 2};
    check_results("max_line");

    // req1 sends one char then goes quiet while req3 waits
    push_str(1, "q");
    cycle();
    push_str(3, "r\n");
    drain("timeout", 4);
    lat = (pulse_cyc.size() > 0 && sink_cyc.size() > 0) ? pulse_cyc[0] - sink_cyc[0] : -1;
    chk("timeout latency", 32'(lat), 32'd8);
    add_exp("q", 1);
    add_exp("r\n", 3);
    want_pulse = '{2, 0};
    check_results("timeout");

    // sink backpressure: 5 cycles on 'p', then 10 (longer than the timeout) on 'q'
    push_str(0, "pq\n");
    sp = 0; sq = 0; stall = 0; n = 0;
    while ((pending() > 0 || m_ov) && n < 100) begin
      if (!sp && m_ov && m_och == "p") begin sp = 1; stall = 5; end
      if (!sq && m_ov && m_och == "q") begin sq = 1; stall = 10; end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      cycle();
      n++;
    end
    out_ready = 1'b1;
    repeat (4) cycle();
    add_exp("pq\n", 0);
    want_pulse = '{0};
    check_results("backpressure");

    // reset while a stalled char sits in the output register
    push_str(3, "st\n");
    seen = 0; n = 0;
    while (seen < 2 && n < 50) begin
      out_ready = !(m_ov && m_och == "s");
      if (!out_ready) seen++;
      cycle();
      n++;
    end
    chk("mid reset reached", 32'(seen), 32'd2);
    q[3].delete();
    reset     = 1'b0;
    out_ready = 1'b0;
    cycle();
    chk("mid reset out_valid", 32'(out_valid), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    check_results("mid_reset");

    // pointer restarted at 0 by reset: req0 before req3
    push_str(0, "u\n");
    push_str(3, "v\n");
    drain("after_reset", 4);
    add_exp("u\n", 0);
    add_exp("v\n", 3);
    want_pulse = '{0, 0};
    check_results("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
